// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 5-stage MIPS core.
// Holds the fetched instruction and its PC and presents the decode fields to ID.
// Also detects load-use hazards, handles branch flush, and keeps saturating
// stall and flush counters for debug.
module if_id_stage #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pc_in,
  input  logic             flush_in,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic             valid_out,
  output logic [5:0]       opcode_out,
  output logic [4:0]       rs_out,
  output logic [4:0]       rt_out,
  output logic [4:0]       rd_out,
  output logic [5:0]       funct_out,
  output logic [31:0]      imm_sext_out,
  output logic             stall_out,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Increment that sticks at all-ones, so a long debug run never wraps to zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Opcodes that read rt as a source; all others write rt instead
  function automatic logic reads_rt(input logic [5:0] op);
    case (op)
      6'h00, 6'h04, 6'h05, 6'h2B: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  logic [31:0]        instr_p1;
  logic [31:0]        pc_p1;
  logic               vld_p1;
  logic [CNT_W-1:0]   stall_cnt_p1;
  logic [CNT_W-1:0]   flush_cnt_p1;
  logic signed [15:0] imm_p1;
  logic signed [31:0] imm_sext_p1;
  logic               uses_rt;
  logic               hazard;

  // ---- IF -> ID boundary: flush beats stall, stall beats normal capture ----
  // Pipeline register and debug counters
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1     <= NOP_WORD;
      pc_p1        <= 32'd0;
      vld_p1       <= 1'b0;
      stall_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
    end else if (flush_in) begin
      instr_p1     <= NOP_WORD;
      pc_p1        <= 32'd0;
      vld_p1       <= 1'b0;
      flush_cnt_p1 <= sat_inc(flush_cnt_p1);
    end else if (hazard) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end else begin
      instr_p1     <= instr_in;
      pc_p1        <= pc_in;
      vld_p1       <= 1'b1;
    end
  end

  // ---- ID-side decode: pure slices of the registered word, no added latency ----
  assign imm_p1      = signed'(instr_p1[15:0]);
  assign imm_sext_p1 = 32'(imm_p1);
  assign uses_rt     = reads_rt(instr_p1[31:26]);

  // Load-use hazard against the load sitting in ID/EX; $0 and bubbles never stall
  always_comb begin
    hazard = 1'b0;
    if (vld_p1 && !flush_in && idex_mem_read && (idex_rt != 5'd0))
      hazard = (idex_rt == instr_p1[25:21]) ||
               (uses_rt && (idex_rt == instr_p1[20:16]));
  end

  assign instr_out    = instr_p1;
  assign pc_out       = pc_p1;
  assign valid_out    = vld_p1;
  assign opcode_out   = instr_p1[31:26];
  assign rs_out       = instr_p1[25:21];
  assign rt_out       = instr_p1[20:16];
  assign rd_out       = instr_p1[15:11];
  assign funct_out    = instr_p1[5:0];
  assign imm_sext_out = imm_sext_p1;
  assign stall_out    = hazard;
  assign stall_count  = stall_cnt_p1;
  assign flush_count  = flush_cnt_p1;

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register between the instruction fetch stage and the register-read/decode stage of the 5-stage MIPS core.
- Captures the fetched instruction and its PC, and presents registered decode fields to ID.
- Detects load-use hazards against the instruction in EX and drives the fetch-side stall line.
- Handles branch flush and keeps saturating stall/flush event counters for debug.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count saturating counters.
- NOP_WORD, 32'h0000_0000, instruction word loaded on reset or flush (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; takes effect on a rising clk edge while high.
- instr_in  in  32  instruction word from fetch.
- pc_in  in  32  PC of instr_in.
- flush_in  in  1  branch/jump taken in EX; squash the IF/ID contents.
- idex_mem_read  in  1  instruction in ID/EX is a load (lw).
- idex_rt  in  5  destination register of that load.
- instr_out  out  32  registered instruction.
- pc_out  out  32  registered PC.
- valid_out  out  1  instr_out is a real instruction, not a bubble.
- opcode_out  out  6  instr_out[31:26].
- rs_out  out  5  instr_out[25:21].
- rt_out  out  5  instr_out[20:16].
- rd_out  out  5  instr_out[15:11].
- funct_out  out  6  instr_out[5:0].
- imm_sext_out  out  32  instr_out[15:0] sign-extended.
- stall_out  out  1  combinational; to fetch Stall and to ID/EX bubble insert.
- stall_count  out  CNT_W  saturating count of stalled cycles.
- flush_count  out  CNT_W  saturating count of flush events.

Behaviour:
- Reset (sync, high at posedge):
  - instr_out = NOP_WORD; pc_out = 0; valid_out = 0.
  - All decode fields are derived from NOP_WORD, so they are 0.
  - stall_count = 0; flush_count = 0.
  - Reset overrides flush_in and stall.
- Decode fields are pure slices and sign-extension of the registered instr_out. They add no latency.
- uses_rt is asserted when opcode_out is 0x00 (R-type), 0x04 (beq), 0x05 (bne) or 0x2B (sw). For every other opcode rt is treated as a destination, not a source.
- stall_out = valid_out & ~flush_in & idex_mem_read & (idex_rt != 0) & ((idex_rt == rs_out) | (uses_rt & (idex_rt == rt_out))).
- Register update priority at each posedge when not in reset:
  1. flush_in = 1:
     - instr_out <= NOP_WORD; pc_out <= 0; valid_out <= 0.
     - flush_count increments, saturating at all-ones.
     - Flush overrides stall in the same cycle; stall_count does not increment.
  2. stall_out = 1:
     - instr_out, pc_out and valid_out hold their values.
     - stall_count increments, saturating.
  3. Otherwise:
     - instr_out <= instr_in; pc_out <= pc_in; valid_out <= 1.
- Latency: instr_in/pc_in appear on the outputs 1 cycle after capture.
- Because fetch holds its PC while stall_out is high, a load-use hazard costs exactly 1 stall cycle. On the next cycle the load has left ID/EX, so stall_out deasserts and the held instruction advances.
- Counters wrap neither up nor down: once at all-ones they stay there until reset.
- When a bubble is held (valid_out = 0), stall_out is never asserted.
- Register $0 never triggers a stall, even when idex_rt matches rs or rt.
- If reset is asserted mid-stall or mid-flush, the next edge returns the block to the reset state.

Test Plan:
- Reset check: hold reset for 2 cycles with instr_in = 0x8C08_0004 -> instr_out = 0, pc_out = 0, valid_out = 0, stall_out = 0, both counters 0.
- Normal flow: after reset release, drive pc_in = 4 with instr_in = 0x0109_5020 (add $10,$8,$9), then pc_in = 8 -> one cycle later pc_out = 4, rs_out = 8, rt_out = 9, rd_out = 10, funct_out = 0x20, valid_out = 1.
- Load-use stall:
  - instr_out = add $10,$8,$9 with idex_mem_read = 1 and idex_rt = 9 -> stall_out = 1 and outputs hold for 1 edge; stall_count = 1.
  - Then drop idex_mem_read -> stall_out = 0 and the next instruction is captured.
- No false stall:
  - idex_rt = 0 -> no stall.
  - instr_out = addi $9,$8,-1 (0x2109_FFFF) with idex_rt = 9 -> no stall, because rt is a destination; imm_sext_out = 0xFFFF_FFFF.
- Flush beats stall: set up a stall condition and assert flush_in in the same cycle -> stall_out = 0; next edge gives valid_out = 0 and instr_out = 0; flush_count = 1, stall_count unchanged.
- Saturation: with CNT_W = 2, hold the stall condition for 6 cycles -> stall_count reaches 3 and stays at 3.
